// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared FSM encoding and constants for the data-memory responder
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  localparam int          CNT_W             = 4;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;

  // Word stores need a word-aligned address, half stores a half-aligned one.
  function automatic logic is_misaligned(input logic [3:0] be, input logic [1:0] a_lo);
    if (be == BE_WORD)
      return a_lo != 2'b00;
    else if (be == BE_HALF_LO || be == BE_HALF_HI)
      return a_lo[0];
    else
      return 1'b0;
  endfunction

endpackage

// File: rtl/dmem_sram_bank.sv
// rtl/dmem_sram_bank.sv - word RAM with synchronous 4-lane byte write and synchronous read
module dmem_sram_bank #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [3:0]            wbe,
  input  logic [31:0]           wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [31:0]           rdata
);

  logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int n = 0; n < 4; n++) begin
        if (wbe[n])
          mem[waddr][8*n +: 8] <= wdata[8*n +: 8];
      end
    end
    if (re)
      rdata <= mem[raddr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - MEM-stage data-memory target with wait states and rbusy stall
// Optional ACCESS_FAULT_EN adds a one-cycle fault output for out-of-range/misaligned accesses.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_enable,
  input  logic        mem_write_enable,
  input  logic [3:0]  byte_enable,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
`ifdef ACCESS_FAULT_EN
  output logic        fault,
`endif
  output logic        rbusy
);

  localparam int unsigned      LOAD_I   = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOAD_I);
  localparam logic [32:0]      SPAN     = 33'd4 << ADDR_WIDTH;

  dmem_state_t           state;
  logic [CNT_W-1:0]      cnt;
  logic                  lat_write;
  logic                  lat_in_range;
  logic [ADDR_WIDTH-1:0] lat_idx;
  logic [3:0]            lat_be;
  logic [31:0]           lat_wdata;
  logic                  rdata_zero;
  logic [31:0]           bank_rdata;

  logic                  req;
  logic [31:0]           offset;
  logic                  live_in_range;
  logic [ADDR_WIDTH-1:0] live_idx;
  logic                  in_idle;
  logic                  complete;
  logic                  cur_write;
  logic                  cur_in_range;
  logic [ADDR_WIDTH-1:0] cur_idx;
  logic [3:0]            cur_be;
  logic [31:0]           cur_wdata;
  logic                  commit_ok;

  assign req           = mem_read_enable | mem_write_enable;
  assign offset        = addr - BASE_ADDR;
  assign live_in_range = (addr >= BASE_ADDR) && ({1'b0, offset} < SPAN);
  assign live_idx      = offset[ADDR_WIDTH+1:2];

  // With zero wait states the access completes on the accepting edge, so the
  // live inputs feed the RAM; otherwise the values latched at acceptance do.
  assign in_idle      = (state == IDLE);
  assign cur_write    = in_idle ? mem_write_enable : lat_write;
  assign cur_in_range = in_idle ? live_in_range    : lat_in_range;
  assign cur_idx      = in_idle ? live_idx         : lat_idx;
  assign cur_be       = in_idle ? byte_enable      : lat_be;
  assign cur_wdata    = in_idle ? write_data       : lat_wdata;
  assign complete     = in_idle ? (req && (WAIT_CYCLES == 0))
                                : ((state == WAIT) && (cnt == '0));

`ifdef ACCESS_FAULT_EN
  logic lat_bad;
  logic live_bad;
  logic cur_bad;
  logic fault_q;

  assign live_bad  = mem_write_enable && is_misaligned(byte_enable, addr[1:0]);
  assign cur_bad   = in_idle ? live_bad : lat_bad;
  assign commit_ok = cur_in_range && !cur_bad;
  assign fault     = fault_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_bad <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      if (in_idle && req)
        lat_bad <= live_bad;
      fault_q <= complete && (!cur_in_range || cur_bad);
    end
  end
`else
  assign commit_ok = cur_in_range;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      rbusy        <= 1'b0;
      lat_write    <= 1'b0;
      lat_in_range <= 1'b0;
      lat_idx      <= '0;
      lat_be       <= '0;
      lat_wdata    <= '0;
      rdata_zero   <= 1'b1;
    end else begin
      if (complete && !cur_write)
        rdata_zero <= !cur_in_range;
      case (state)
        IDLE: begin
          if (req) begin
            lat_write    <= mem_write_enable;
            lat_in_range <= live_in_range;
            lat_idx      <= live_idx;
            lat_be       <= byte_enable;
            lat_wdata    <= write_data;
            if (WAIT_CYCLES == 0) begin
              state <= DONE;
            end else begin
              cnt   <= CNT_LOAD;
              rbusy <= 1'b1;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            rbusy <= 1'b0;
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  dmem_sram_bank #(.ADDR_WIDTH(ADDR_WIDTH)) u_bank (
    .clk   (clk),
    .we    (complete && cur_write && commit_ok),
    .waddr (cur_idx),
    .wbe   (cur_be),
    .wdata (cur_wdata),
    .re    (complete && !cur_write && cur_in_range),
    .raddr (cur_idx),
    .rdata (bank_rdata)
  );

  // The RAM output register only moves on in-range reads; the zero flag
  // covers reset and out-of-range reads without touching the RAM.
  assign read_data = rdata_zero ? 32'h0 : bank_rdata;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed table-driven bench for data_mem_responder
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd, wr;
  logic [3:0]  be;
  logic [31:0] a, d;
  logic [31:0] read_data;
  logic        rbusy;
  logic        rd0, wr0;
  logic [3:0]  be0;
  logic [31:0] a0, d0;
  logic [31:0] read_data0;
  logic        rbusy0;
`ifdef ACCESS_FAULT_EN
  logic        fault, fault0;
`endif

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h1001_0000), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .mem_read_enable(rd), .mem_write_enable(wr),
    .byte_enable(be), .addr(a), .write_data(d), .read_data(read_data),
`ifdef ACCESS_FAULT_EN
    .fault(fault),
`endif
    .rbusy(rbusy)
  );

  data_mem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h1001_0000), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .mem_read_enable(rd0), .mem_write_enable(wr0),
    .byte_enable(be0), .addr(a0), .write_data(d0), .read_data(read_data0),
`ifdef ACCESS_FAULT_EN
    .fault(fault0),
`endif
    .rbusy(rbusy0)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_fault;
  } vec_t;

  vec_t vt[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t v(input logic r, input logic w, input logic [3:0] b,
                             input logic [31:0] ad, input logic [31:0] dd,
                             input logic [31:0] er, input logic ef);
    vec_t t;
    t.rd = r; t.wr = w; t.be = b; t.a = ad; t.d = dd; t.exp_rd = er; t.exp_fault = ef;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One access on the WAIT_CYCLES=2 instance; returns in the DONE cycle.
  task automatic do_access(input string name, input vec_t t);
    int busy;
    @(negedge clk);
    rd = t.rd; wr = t.wr; be = t.be; a = t.a; d = t.d;
    @(posedge clk);
    busy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rbusy) busy++;
      else break;
    end
    check({name, "_busy"}, 32'(busy), 32'd2);
    if (t.rd && !t.wr)
      check({name, "_rdata"}, read_data, t.exp_rd);
`ifdef ACCESS_FAULT_EN
    check({name, "_fault"}, {31'd0, fault}, {31'd0, t.exp_fault});
`endif
    rd = 1'b0; wr = 1'b0;
  endtask

  localparam logic [31:0] W1_AFTER_MIS =
`ifdef ACCESS_FAULT_EN
    32'hDEAD_BEEF;
`else
    32'h9999_9999;
`endif
  localparam logic MIS_FAULT =
`ifdef ACCESS_FAULT_EN
    1'b1;
`else
    1'b0;
`endif

  initial begin
    logic [7:0] pat;

    vt.push_back(v(0, 1, 4'hF, 32'h1001_0004, 32'hDEAD_BEEF, 32'h0, 0));
    vt.push_back(v(1, 0, 4'h0, 32'h1001_0004, 32'h0,         32'hDEAD_BEEF, 0));
    vt.push_back(v(0, 1, 4'hF, 32'h1001_0010, 32'h1122_3344, 32'h0, 0));
    vt.push_back(v(0, 1, 4'h4, 32'h1001_0010, 32'h00AA_0000, 32'h0, 0));
    vt.push_back(v(1, 0, 4'h0, 32'h1001_0010, 32'h0,         32'h11AA_3344, 0));
    vt.push_back(v(0, 1, 4'hF, 32'h1001_0014, 32'hCAFE_F00D, 32'h0, 0));
    vt.push_back(v(0, 1, 4'hC, 32'h1001_0016, 32'h1234_0000, 32'h0, 0));
    vt.push_back(v(1, 0, 4'h0, 32'h1001_0014, 32'h0,         32'h1234_F00D, 0));
    vt.push_back(v(0, 1, 4'hF, 32'h1001_0000, 32'h0102_0304, 32'h0, 0));
    vt.push_back(v(1, 0, 4'h0, 32'h1001_1000, 32'h0,         32'h0, 1));
    vt.push_back(v(0, 1, 4'hF, 32'h1001_1000, 32'hFFFF_FFFF, 32'h0, 1));
    vt.push_back(v(1, 0, 4'h0, 32'h1001_0000, 32'h0,         32'h0102_0304, 0));
    vt.push_back(v(1, 0, 4'h0, 32'h1000_FFFC, 32'h0,         32'h0, 1));
    vt.push_back(v(0, 1, 4'hF, 32'h1001_0FFC, 32'hA5A5_A5A5, 32'h0, 0));
    vt.push_back(v(1, 0, 4'h0, 32'h1001_0FFC, 32'h0,         32'hA5A5_A5A5, 0));
    vt.push_back(v(0, 1, 4'h0, 32'h1001_0004, 32'h0,         32'h0, 0));
    vt.push_back(v(1, 0, 4'h0, 32'h1001_0004, 32'h0,         32'hDEAD_BEEF, 0));
    vt.push_back(v(1, 1, 4'hF, 32'h1001_0020, 32'h7777_7777, 32'h0, 0));
    vt.push_back(v(1, 0, 4'h0, 32'h1001_0020, 32'h0,         32'h7777_7777, 0));
    vt.push_back(v(0, 1, 4'hF, 32'h1001_0005, 32'h9999_9999, 32'h0, MIS_FAULT));
    vt.push_back(v(1, 0, 4'h0, 32'h1001_0004, 32'h0,         W1_AFTER_MIS, 0));
    vt.push_back(v(0, 1, 4'hF, 32'h1001_0008, 32'h0BAD_F00D, 32'h0, 0));

    reset = 1'b0;
    rd = 0; wr = 0; be = 0; a = 0; d = 0;
    rd0 = 0; wr0 = 0; be0 = 0; a0 = 0; d0 = 0;
    repeat (3) @(negedge clk);
    check("reset_rbusy", {31'd0, rbusy}, 32'd0);
    check("reset_rdata", read_data, 32'h0);
    check("reset_rbusy0", {31'd0, rbusy0}, 32'd0);
`ifdef ACCESS_FAULT_EN
    check("reset_fault", {31'd0, fault}, 32'd0);
`endif
    reset = 1'b1;

    for (int i = 0; i < vt.size(); i++)
      do_access($sformatf("vec%0d", i), vt[i]);

    // Held read: one access per IDLE entry, DONE gap each time.
    @(negedge clk);
    rd = 1'b1; a = 32'h1001_0004;
    pat = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pat = {pat[6:0], rbusy};
    end
    rd = 1'b0;
    check("held_rbusy_pattern", {24'd0, pat}, 32'h0000_00CC);
    check("held_rdata", read_data, W1_AFTER_MIS);

    // Reset while the write sits in WAIT: it must never commit.
    @(negedge clk);
    wr = 1'b1; be = 4'hF; a = 32'h1001_0008; d = 32'h55AA_55AA;
    @(posedge clk);
    @(negedge clk);
    check("midwait_rbusy_pre", {31'd0, rbusy}, 32'd1);
    reset = 1'b0;
    #1;
    check("midwait_rbusy_rst", {31'd0, rbusy}, 32'd0);
    check("midwait_rdata_rst", read_data, 32'h0);
    wr = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    do_access("midwait_read", v(1, 0, 4'h0, 32'h1001_0008, 32'h0, 32'h0BAD_F00D, 0));

    // Zero wait states: write then read of word 0 with rbusy never high.
    @(negedge clk);
    wr0 = 1'b1; be0 = 4'hF; a0 = 32'h1001_0000; d0 = 32'h1357_9BDF;
    @(negedge clk);
    check("w0_rbusy_a", {31'd0, rbusy0}, 32'd0);
    wr0 = 1'b0; rd0 = 1'b1;
    @(negedge clk);
    check("w0_rbusy_b", {31'd0, rbusy0}, 32'd0);
    check("w0_rdata_done_ignored", read_data0, 32'h0);
    @(negedge clk);
    check("w0_rbusy_c", {31'd0, rbusy0}, 32'd0);
    check("w0_rdata", read_data0, 32'h1357_9BDF);
    rd0 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
